bios_watchdog_multi: RTL and testbench

BIOS_WATCHDOG_MULTI -- requirements
Module: bios_watchdog_multi

---
 rtl/bios_watchdog_multi_if.sv | 24 ++
 rtl/bios_watchdog_multi.sv | 108 ++++++++++
 tb/tb_bios_watchdog_multi.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bios_watchdog_multi_if.sv
// Control/status bundle of the BIOS boot watchdog; the clock and the power-up reset stay outside it.
interface bios_watchdog_multi_if #(parameter int RETRY_W = 2);
  logic               MainReset;
  logic               PS_ONn;
  logic               Strobe125msec;
  logic               WriteBiosWD;
  logic [7:0]         BiosRegister;
  logic               BiosFinished;
  logic               BiosPowerOff;
  logic               ForceSwap;
  logic               Lockout;
  logic [2:0]         State;
  logic [RETRY_W-1:0] RetryCount;
  logic [1:0]         DPx;

  modport slave (
    input  MainReset, PS_ONn, Strobe125msec, WriteBiosWD, BiosRegister,
    output BiosFinished, BiosPowerOff, ForceSwap, Lockout, State, RetryCount, DPx
  );
  modport master (
    output MainReset, PS_ONn, Strobe125msec, WriteBiosWD, BiosRegister,
    input  BiosFinished, BiosPowerOff, ForceSwap, Lockout, State, RetryCount, DPx
  );
endinterface

// File: rtl/bios_watchdog_multi.sv
// BIOS boot watchdog: boot/kick timers, BIOS-swap on expiry, retry budget ending in a sticky lockout.
module bios_watchdog_multi #(
  parameter int         TOTAL_W     = 10,
  parameter int         KICK_W      = 6,
  parameter int         RETRY_W     = 2,
  parameter int         RETRY_MAX   = 2,
  parameter logic [7:0] CODE_NOKICK = 8'h55,
  parameter logic [7:0] CODE_HOLD   = 8'h29,
  parameter logic [7:0] CODE_DONE   = 8'hFF
) (
  input logic                  LpcClock,
  input logic                  Reset,
  bios_watchdog_multi_if.slave bif
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_HOLD = 3'd2, S_DONE = 3'd3, S_EXPIRED = 3'd4, S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [RETRY_W-1:0] RMAX = RETRY_W'(RETRY_MAX);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_t             r_state, w_next;
  logic [TOTAL_W-1:0] r_boot;
  logic [KICK_W-1:0]  r_kick;
  logic [RETRY_W-1:0] r_retry;
  logic               r_fin, r_poff, r_swap, r_lock;
  logic               w_rearm, w_expire, w_kick_clr;

  // Assert immediately, release two LpcClock edges later.
  always_ff @(posedge LpcClock or negedge Reset)
    if (!Reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  assign w_rearm    = !bif.MainReset && bif.PS_ONn;
  assign w_expire   = r_boot[TOTAL_W-1] || r_kick[KICK_W-1];
  assign w_kick_clr = bif.WriteBiosWD || (bif.BiosRegister == CODE_NOKICK);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bif.MainReset) w_next = S_RUN;
      S_RUN:
        if (w_rearm)                             w_next = S_IDLE;
        else if (bif.BiosRegister == CODE_DONE)  w_next = S_DONE;
        else if (bif.BiosRegister == CODE_HOLD)  w_next = S_HOLD;
        else if (w_expire)                       w_next = S_EXPIRED;
      S_HOLD:
        if (w_rearm)                             w_next = S_IDLE;
        else if (bif.BiosRegister == CODE_DONE)  w_next = S_DONE;
        else if (bif.BiosRegister != CODE_HOLD)  w_next = S_RUN;
      S_DONE:    if (w_rearm) w_next = S_IDLE;
      // An exhausted budget locks out even if the host re-arms in the same cycle.
      S_EXPIRED:
        if (r_retry >= RMAX)                     w_next = S_LOCKOUT;
        else if (w_rearm)                        w_next = S_IDLE;
      S_LOCKOUT: w_next = S_LOCKOUT;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge LpcClock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_boot  <= '0;
      r_kick  <= '0;
      r_retry <= '0;
      r_fin   <= 1'b0;
      r_poff  <= 1'b0;
      r_swap  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_swap  <= 1'b0;
      if (w_next == S_IDLE) begin
        r_boot <= '0;
        r_kick <= '0;
        r_fin  <= 1'b0;
        r_poff <= 1'b0;
      end else if (r_state == S_RUN) begin
        // Timers saturate on their MSB so an expiry can never be lost to a wrap.
        if (bif.Strobe125msec && !r_boot[TOTAL_W-1]) r_boot <= r_boot + 1'b1;
        if (w_kick_clr)                                   r_kick <= '0;
        else if (bif.Strobe125msec && !r_kick[KICK_W-1]) r_kick <= r_kick + 1'b1;
        if (w_next == S_EXPIRED) begin
          r_swap <= 1'b1;
          r_poff <= 1'b1;
          if (r_retry != '1) r_retry <= r_retry + 1'b1;
        end
      end
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_fin   <= 1'b1;
        r_retry <= '0;
      end
      if (w_next == S_LOCKOUT) r_lock <= 1'b1;
    end
  end

  assign bif.State        = r_state;
  assign bif.RetryCount   = r_retry;
  assign bif.BiosFinished = r_fin;
  assign bif.BiosPowerOff = r_poff;
  assign bif.ForceSwap    = r_swap;
  assign bif.Lockout      = r_lock;
  assign bif.DPx          = {(r_state == S_RUN) && (r_boot != '0),
                             (r_state == S_RUN) && (r_kick != '0)};
endmodule

// File: tb/tb_bios_watchdog_multi.sv
// Directed scenarios then random traffic, all checked against a strobe-counting reference model.
module tb_bios_watchdog_multi;
  localparam int BOOT_LIM = 8;   // 2^(TOTAL_W-1) with TOTAL_W=4
  localparam int KICK_LIM = 4;   // 2^(KICK_W-1) with KICK_W=3
  localparam int RMAX     = 2;
  localparam int RSAT     = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Reference model: state number, strobes counted by each timer, flags.
  int m_st, m_boot, m_kick, m_retry, m_sync;
  bit m_fin, m_poff, m_swap, m_lock;

  bios_watchdog_multi_if #(.RETRY_W(2)) bif ();

  bios_watchdog_multi #(
    .TOTAL_W(4), .KICK_W(3), .RETRY_W(2), .RETRY_MAX(2),
    .CODE_NOKICK(8'h55), .CODE_HOLD(8'h29), .CODE_DONE(8'hFF)
  ) dut (
    .LpcClock(clk),
    .Reset   (rst_n),
    .bif     (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [1:0] dpx;
    dpx = {(m_st == 1) && (m_boot > 0), (m_st == 1) && (m_kick > 0)};
    chk({tag, ".State"}, 8'(bif.State), 8'(m_st));
    chk({tag, ".Retry"}, 8'(bif.RetryCount), 8'(m_retry));
    chk({tag, ".Fin"},   8'(bif.BiosFinished), 8'(m_fin));
    chk({tag, ".Poff"},  8'(bif.BiosPowerOff), 8'(m_poff));
    chk({tag, ".Swap"},  8'(bif.ForceSwap), 8'(m_swap));
    chk({tag, ".Lock"},  8'(bif.Lockout), 8'(m_lock));
    chk({tag, ".DPx"},   8'(bif.DPx), 8'(dpx));
  endtask

  task automatic model_zero();
    m_st = 0; m_boot = 0; m_kick = 0; m_retry = 0; m_sync = 0;
    m_fin = 0; m_poff = 0; m_swap = 0; m_lock = 0;
  endtask

  // Advance the model across one clock edge using the inputs present before it.
  task automatic model_edge();
    int st, bt, kk, rt;
    bit fin, poff, swap, lock, rearm;
    logic [7:0] rg;
    if (!rst_n) begin m_sync = 0; return; end
    if (m_sync < 2) begin m_sync++; return; end
    st = m_st; bt = m_boot; kk = m_kick; rt = m_retry;
    fin = m_fin; poff = m_poff; lock = m_lock; swap = 0;
    rearm = !bif.MainReset && bif.PS_ONn;
    rg = bif.BiosRegister;
    case (m_st)
      0: if (bif.MainReset) st = 1;
      1: begin
        if (bif.Strobe125msec) bt = (m_boot + 1 > BOOT_LIM) ? BOOT_LIM : m_boot + 1;
        if (bif.WriteBiosWD || rg == 8'h55) kk = 0;
        else if (bif.Strobe125msec) kk = (m_kick + 1 > KICK_LIM) ? KICK_LIM : m_kick + 1;
        if (rg == 8'hFF) begin st = 3; fin = 1; rt = 0; end
        else if (rg == 8'h29) st = 2;
        else if (m_boot >= BOOT_LIM || m_kick >= KICK_LIM) begin
          st = 4; swap = 1; poff = 1; rt = (m_retry + 1 > RSAT) ? RSAT : m_retry + 1;
        end
      end
      2: if (rg == 8'hFF) begin st = 3; fin = 1; rt = 0; end
         else if (rg != 8'h29) st = 1;
      4: if (m_retry >= RMAX) begin st = 5; lock = 1; end
      default: ;
    endcase
    if (rearm && (m_st <= 3 || (m_st == 4 && m_retry < RMAX))) begin
      st = 0; bt = 0; kk = 0; fin = 0; poff = 0; swap = 0; rt = m_retry;
    end
    m_st = st; m_boot = bt; m_kick = kk; m_retry = rt;
    m_fin = fin; m_poff = poff; m_swap = swap; m_lock = lock;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic strobe_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bif.Strobe125msec = 1'b1; step(tag);
      bif.Strobe125msec = 1'b0; step(tag);
    end
  endtask

  task automatic reset_assert(input string tag);
    rst_n = 1'b0;
    model_zero();
    #1;
    compare_all(tag);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    step("sync1");
    step("sync2");
  endtask

  task automatic set_run_inputs();
    bif.MainReset = 1'b1; bif.PS_ONn = 1'b0; bif.BiosRegister = 8'h00;
    bif.WriteBiosWD = 1'b0; bif.Strobe125msec = 1'b0;
  endtask

  task automatic rearm(input string tag);
    bif.MainReset = 1'b0; bif.PS_ONn = 1'b1;
    step(tag);
    bif.MainReset = 1'b1; bif.PS_ONn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    bif.MainReset = 1'b0; bif.PS_ONn = 1'b1; bif.Strobe125msec = 1'b0;
    bif.WriteBiosWD = 1'b0; bif.BiosRegister = 8'h00;
    model_zero();
    #2;
    reset_assert("por");
    step("por_hold");

    // Kick timer expiry with no kicks
    set_run_inputs();
    release_reset();
    step("a_run");
    chk("a_run_state", 8'(bif.State), 8'd1);
    strobe_n(4, "a_strobe");
    chk("a_exp_state", 8'(bif.State), 8'd4);
    chk("a_exp_swap",  8'(bif.ForceSwap), 8'd1);
    chk("a_exp_poff",  8'(bif.BiosPowerOff), 8'd1);
    chk("a_exp_retry", 8'(bif.RetryCount), 8'd1);
    step("a_exp2");
    chk("a_swap_once", 8'(bif.ForceSwap), 8'd0);
    chk("a_exp_wait",  8'(bif.State), 8'd4);

    // Regular kicks, boot timer expiry, then lockout
    bif.MainReset = 1'b0; bif.PS_ONn = 1'b1;
    step("b_rearm");
    chk("b_rearm_state", 8'(bif.State), 8'd0);
    chk("b_rearm_poff",  8'(bif.BiosPowerOff), 8'd0);
    chk("b_rearm_retry", 8'(bif.RetryCount), 8'd1);
    bif.MainReset = 1'b1; bif.PS_ONn = 1'b0;
    step("b_run");
    for (int i = 1; i <= 8; i++) begin
      bif.Strobe125msec = 1'b1; bif.WriteBiosWD = (i % 3 == 0);
      step("b_strobe");
      if (i == 3) chk("b_kick_clr_wins", 8'(bif.DPx), 8'd2);
      bif.Strobe125msec = 1'b0; bif.WriteBiosWD = 1'b0;
      step("b_gap");
    end
    chk("b_exp_state", 8'(bif.State), 8'd4);
    chk("b_exp_retry", 8'(bif.RetryCount), 8'd2);
    chk("b_exp_swap",  8'(bif.ForceSwap), 8'd1);
    step("b_lock");
    chk("b_lock_state", 8'(bif.State), 8'd5);
    chk("b_lock_flag",  8'(bif.Lockout), 8'd1);
    bif.MainReset = 1'b0; bif.PS_ONn = 1'b1; bif.BiosRegister = 8'hFF;
    step("b_lock_rearm"); step("b_lock_rearm");
    chk("b_lock_ignore", 8'(bif.State), 8'd5);
    chk("b_lock_poff",   8'(bif.BiosPowerOff), 8'd1);
    reset_assert("b_rst");
    chk("b_rst_lock", 8'(bif.Lockout), 8'd0);

    // Hold freezes timers, then DONE clears the retry count
    set_run_inputs();
    release_reset();
    step("c_run");
    strobe_n(4, "c_exp");
    rearm("c_rearm");
    step("c_run2");
    strobe_n(2, "c_pre");
    bif.BiosRegister = 8'h29;
    step("c_hold");
    chk("c_hold_state", 8'(bif.State), 8'd2);
    strobe_n(10, "c_frozen");
    chk("c_hold_still", 8'(bif.State), 8'd2);
    bif.BiosRegister = 8'h00;
    step("c_resume");
    chk("c_resume_state", 8'(bif.State), 8'd1);
    chk("c_resume_dpx",   8'(bif.DPx), 8'd3);
    strobe_n(1, "c_count");
    chk("c_no_expire", 8'(bif.State), 8'd1);
    bif.BiosRegister = 8'hFF;
    step("c_done");
    chk("c_done_state", 8'(bif.State), 8'd3);
    chk("c_done_fin",   8'(bif.BiosFinished), 8'd1);
    chk("c_done_retry", 8'(bif.RetryCount), 8'd0);
    strobe_n(2, "c_done_idle");
    chk("c_done_stays", 8'(bif.State), 8'd3);
    bif.BiosRegister = 8'h00;
    rearm("c_leave");
    chk("c_leave_fin", 8'(bif.BiosFinished), 8'd0);

    // DONE wins over a same-cycle kick expiry
    step("d_run");
    strobe_n(3, "d_pre");
    bif.Strobe125msec = 1'b1; bif.BiosRegister = 8'hFF;
    step("d_done");
    bif.Strobe125msec = 1'b0;
    chk("d_done_state", 8'(bif.State), 8'd3);
    chk("d_no_swap",    8'(bif.ForceSwap), 8'd0);
    step("d_after");
    chk("d_no_swap2", 8'(bif.ForceSwap), 8'd0);

    // Asynchronous reset in the middle of RUN
    bif.BiosRegister = 8'h00;
    rearm("e_rearm");
    step("e_run");
    strobe_n(2, "e_pre");
    chk("e_pre_dpx", 8'(bif.DPx), 8'd3);
    reset_assert("e_async");
    chk("e_async_state", 8'(bif.State), 8'd0);
    chk("e_async_dpx",   8'(bif.DPx), 8'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (rst_n && $urandom_range(0, 199) == 0) reset_assert("rnd_rst");
      else if (!rst_n && $urandom_range(0, 3) == 0) rst_n = 1'b1;
      bif.MainReset     = ($urandom_range(0, 15) != 0);
      bif.PS_ONn        = 1'($urandom_range(0, 1));
      bif.Strobe125msec = ($urandom_range(0, 2) == 0);
      bif.WriteBiosWD   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: bif.BiosRegister = 8'h00;
          1: bif.BiosRegister = 8'h29;
          2: bif.BiosRegister = 8'h55;
          3: bif.BiosRegister = 8'hFF;
          default: bif.BiosRegister = 8'($urandom);
        endcase
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
